// File: rtl/branch_pred_ctrl.sv
// -----------------------------------------------------------------------------
// branch_pred_ctrl
//
// Fetch-side next-PC controller. It owns a direct-mapped branch target buffer
// (valid, tag, target, 2-bit saturating counter per entry) that is looked up
// combinationally with the fetch PC. It also resolves execute-stage branches
// against the prediction that travelled down the pipe with them. From these it
// produces the 3-bit select code for the next-PC mux and the candidate
// addresses that mux needs.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   if_pc             PC currently in fetch (lookup address)
//   hazard_stall      stall request from the hazard unit
//   ex_valid          execute instruction is live
//   ex_is_branch      execute instruction is a conditional branch / JAL
//   ex_pc             PC of the execute instruction (update address)
//   ex_taken          resolved direction
//   ex_target         resolved target
//   ex_pred_taken     prediction that was made for this instruction at fetch
//   pc_sel            next-PC mux select (PCMUX_* code)
//   predicted_target  BTB target for if_pc, 0 on miss
//   corr_pc4          ex_pc + 4, fall-through correction address
//   pred_taken        fetch-stage prediction, piped to execute
//   flush             squash IF/ID and ID/EX this cycle
//
// There is no handshake here. Every input is sampled each cycle. A BTB
// update happens on any rising edge where ex_valid && ex_is_branch is high.
// -----------------------------------------------------------------------------

`ifndef PCMUX_CURR_PC4
`define PCMUX_CURR_PC4 3'd0
`endif
`ifndef PCMUX_BRANCH
`define PCMUX_BRANCH   3'd1
`endif
`ifndef PCMUX_CORR_PC4
`define PCMUX_CORR_PC4 3'd2
`endif
`ifndef PCMUX_HAZARD
`define PCMUX_HAZARD   3'd3
`endif
`ifndef PCMUX_PRED_TGT
`define PCMUX_PRED_TGT 3'd4
`endif

module branch_pred_ctrl #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 32 - 2 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic        hazard_stall,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  output logic [2:0]  pc_sel,
  output logic [31:0] predicted_target,
  output logic [31:0] corr_pc4,
  output logic        pred_taken,
  output logic        flush
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  // BTB storage. Only valid and ctr are reset. A stale tag/target is never
  // observed while its valid bit is clear.
  logic [ENTRIES-1:0]  valid_q;
  logic [1:0]          ctr_q [ENTRIES];
  logic [TAG_BITS-1:0] tag_q [ENTRIES];
  logic [31:0]         tgt_q [ENTRIES];

  logic [INDEX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_BITS-1:0]   if_tag, ex_tag;
  logic                  if_hit, ex_hit;
  logic                  ex_upd;
  logic                  mis_nt, mis_t;
  logic                  lookup_taken;

  // Instruction PCs are word aligned, so the low two bits carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  assign if_idx = if_pc[INDEX_BITS+1:2];
  assign if_tag = if_pc[31:INDEX_BITS+2];
  assign ex_idx = ex_pc[INDEX_BITS+1:2];
  assign ex_tag = ex_pc[31:INDEX_BITS+2];

  // Lookup reads the registered table. A same-cycle update therefore
  // becomes visible only on the following cycle.
  assign if_hit       = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign lookup_taken = if_hit && ctr_q[if_idx][1];
  assign ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ex_upd       = ex_valid && ex_is_branch;

  // A taken branch is a missed-taken redirect in three cases: it was not
  // predicted taken, the prediction came from an entry that has since been
  // replaced, or the stored target no longer matches the resolved target.
  assign mis_nt = ex_upd && ex_taken &&
                  (!ex_pred_taken || !ex_hit || (tgt_q[ex_idx] != ex_target));
  assign mis_t  = ex_upd && !ex_taken && ex_pred_taken;

  assign corr_pc4 = ex_pc + 32'd4;

  always_comb begin
    pc_sel           = `PCMUX_CURR_PC4;
    pred_taken       = 1'b0;
    flush            = 1'b0;
    predicted_target = 32'd0;
    if (!rst) begin
      flush            = mis_nt || mis_t;
      predicted_target = if_hit ? tgt_q[if_idx] : 32'd0;
      // The fetched instruction is squashed on a flush, so its prediction is
      // dropped rather than carried down the pipe.
      pred_taken       = lookup_taken && !(mis_nt || mis_t);
      if (mis_nt)            pc_sel = `PCMUX_BRANCH;
      else if (mis_t)        pc_sel = `PCMUX_CORR_PC4;
      else if (hazard_stall) pc_sel = `PCMUX_HAZARD;
      else if (lookup_taken) pc_sel = `PCMUX_PRED_TGT;
      else                   pc_sel = `PCMUX_CURR_PC4;
    end
  end

  // Valid bits and direction counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b00;
    end else if (ex_upd) begin
      if (ex_hit) begin
        if (ex_taken) begin
          if (ctr_q[ex_idx] != 2'b11) ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'b01;
        end else begin
          if (ctr_q[ex_idx] != 2'b00) ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'b01;
        end
      end else if (ex_taken) begin
        // Allocate as weakly taken. This replaces any aliasing entry.
        valid_q[ex_idx] <= 1'b1;
        ctr_q[ex_idx]   <= 2'b10;
      end
    end
  end

  // Tag and target. Both are written on every taken resolution. On a hit the
  // tag write is a no-op and the target tracks the latest destination.
  always_ff @(posedge clk) begin
    if (ex_upd && ex_taken) begin
      tag_q[ex_idx] <= ex_tag;
      tgt_q[ex_idx] <= ex_target;
    end
  end

endmodule
